fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/bp.sv | 16 +
 rtl/redir_sel.sv | 46 ++++
 rtl/fetch_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned ILEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_TRAP    = 3'd1,
    CAUSE_MISPRED = 3'd2,
    CAUSE_FENCE   = 3'd3,
    CAUSE_TAKEN   = 3'd4,
    CAUSE_SEQ     = 3'd5
  } redir_cause_e;

  // Decode slot payload: fetched word plus the pc it came from.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] inst;
  } dec_slot_t;

endpackage

// File: rtl/bp.sv
// Branch predictor port adapter: the prediction tables sit outside this slice
// and deliver taken/target for the current pc; this block hands them to fetch.
module bp
  import fetch_pkg::*;
(
  input  logic            taken_i,
  input  logic [XLEN-1:0] paddr_i,
  output logic            taken_o,
  output logic [XLEN-1:0] paddr_o
);

  // Prediction for the pc currently presented on the request channel.
  assign taken_o = taken_i;
  assign paddr_o = paddr_i;

endmodule

// File: rtl/redir_sel.sv
// Next-pc priority selector: trap > mispred > fence_i > taken > pc+4.
// fence_i and taken only count while fetching; the taken/+4 step only when a
// request actually transfers.
module redir_sel
  import fetch_pkg::*;
(
  input  logic            run_i,
  input  logic            step_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            mispred_i,
  input  logic [XLEN-1:0] tp_addr_i,
  input  logic            fence_req_i,
  input  logic [XLEN-1:0] fence_pc_i,
  input  logic            taken_i,
  input  logic [XLEN-1:0] paddr_i,
  input  logic [XLEN-1:0] pc_i,
  output redir_cause_e    cause_o,
  output logic [XLEN-1:0] next_pc_o
);

  // Priority chain; pc arithmetic wraps modulo 2^64.
  always_comb begin
    cause_o   = CAUSE_NONE;
    next_pc_o = pc_i;
    if (trap_i) begin
      cause_o   = CAUSE_TRAP;
      next_pc_o = trap_addr_i;
    end else if (mispred_i) begin
      cause_o   = CAUSE_MISPRED;
      next_pc_o = tp_addr_i;
    end else if (run_i && fence_req_i) begin
      cause_o   = CAUSE_FENCE;
      next_pc_o = fence_pc_i + XLEN'(INST_BYTES);
    end else if (run_i && step_i) begin
      if (taken_i) begin
        cause_o   = CAUSE_TAKEN;
        next_pc_o = paddr_i;
      end else begin
        cause_o   = CAUSE_SEQ;
        next_pc_o = pc_i + XLEN'(INST_BYTES);
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect
// handling with kill of in-flight responses, and an instruction-fence
// drain/flush sequence. Optional perf counters under FETCH_CTRL_PERF_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = 64'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            mispred,
  input  logic [XLEN-1:0] tp_addr,
  input  logic            fence_i,
  input  logic [XLEN-1:0] fence_pc,
  input  logic            taken,
  input  logic [XLEN-1:0] paddr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            icache_inv_req,
  input  logic            icache_inv_done,
`ifdef FETCH_CTRL_PERF_EN
  output logic [XLEN-1:0] perf_redirects,
  output logic [XLEN-1:0] perf_stalls,
`endif
  output logic            inst_valid,
  input  logic            dec_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_addr
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            out_q, out_d;
  logic            kill_q, kill_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [XLEN-1:0] rq_addr_q, rq_addr_d;
  dec_slot_t       slot_q, slot_d;
  logic            inst_valid_q, inst_valid_d;
  logic            inv_q, inv_d;

  logic            run_c;
  logic            redir_c;
  logic            xfer_c;
  logic            rsp_c;
  logic            pred_taken;
  logic [XLEN-1:0] pred_addr;
  redir_cause_e    cause;
  logic [XLEN-1:0] next_pc;

  // Request is offered only when the decode slot will be free and nothing
  // this cycle is about to move the pc elsewhere.
  assign run_c          = (state_q == RUN);
  assign redir_c        = trap_valid || mispred;
  assign imem_req_valid = rst && run_c && !out_q && (!inst_valid_q || dec_ready)
                          && !redir_c && !fence_i;
  assign imem_req_addr  = pc_q;
  assign xfer_c         = imem_req_valid && imem_req_ready;
  assign rsp_c          = imem_rsp_valid && out_q;

  assign inst_valid     = inst_valid_q;
  assign inst           = slot_q.inst;
  assign inst_addr      = slot_q.addr;
  assign icache_inv_req = inv_q;

  bp u_bp (
    .taken_i (taken),
    .paddr_i (paddr),
    .taken_o (pred_taken),
    .paddr_o (pred_addr)
  );

  redir_sel u_redir_sel (
    .run_i       (run_c),
    .step_i      (xfer_c),
    .trap_i      (trap_valid),
    .trap_addr_i (trap_addr),
    .mispred_i   (mispred),
    .tp_addr_i   (tp_addr),
    .fence_req_i (fence_i),
    .fence_pc_i  (fence_pc),
    .taken_i     (pred_taken),
    .paddr_i     (pred_addr),
    .pc_i        (pc_q),
    .cause_o     (cause),
    .next_pc_o   (next_pc)
  );

  // Next-state: request/response bookkeeping, redirects and fence sequencing.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    out_d        = out_q;
    kill_d       = kill_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    rq_addr_d    = rq_addr_q;
    slot_d       = slot_q;
    inst_valid_d = inst_valid_q;

    if (inst_valid_q && dec_ready) begin
      inst_valid_d = 1'b0;
    end

    // Killed responses, drain responses and ones racing a redirect/fence
    // retire the request but never reach decode.
    if (rsp_c) begin
      out_d  = 1'b0;
      kill_d = 1'b0;
      if (!kill_q && run_c && !redir_c && !fence_i) begin
        inst_valid_d = 1'b1;
        slot_d.addr  = rq_addr_q;
        slot_d.inst  = imem_rsp_data;
      end
    end

    if (xfer_c) begin
      out_d     = 1'b1;
      kill_d    = 1'b0;
      rq_addr_d = pc_q;
    end

    if (redir_c) begin
      inst_valid_d = 1'b0;
      if (out_q && !rsp_c) begin
        kill_d = 1'b1;
      end
    end

    case (state_q)
      RUN: begin
        case (cause)
          CAUSE_TRAP, CAUSE_MISPRED, CAUSE_TAKEN, CAUSE_SEQ: pc_d = next_pc;
          CAUSE_FENCE: begin
            // pc parks at the resume point while the cache is flushed
            pc_d         = next_pc;
            inst_valid_d = 1'b0;
            state_d      = (out_q && !rsp_c) ? DRAIN : FLUSH;
          end
          default: ;
        endcase
      end
      DRAIN: begin
        if (rsp_c) begin
          state_d = FLUSH;
        end
        if (redir_c) begin
          pend_d    = 1'b1;
          pend_pc_d = next_pc;
        end
      end
      FLUSH: begin
        if (icache_inv_done) begin
          state_d = RUN;
          pend_d  = 1'b0;
          if (redir_c) begin
            pc_d = next_pc;
          end else if (pend_q) begin
            pc_d = pend_pc_q;
          end
        end else if (redir_c) begin
          pend_d    = 1'b1;
          pend_pc_d = next_pc;
        end
      end
      default: state_d = RUN;
    endcase

    inv_d = (state_d == FLUSH);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_VEC;
      out_q        <= 1'b0;
      kill_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_pc_q    <= '0;
      rq_addr_q    <= '0;
      slot_q       <= '0;
      inst_valid_q <= 1'b0;
      inv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_q        <= out_d;
      kill_q       <= kill_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      rq_addr_q    <= rq_addr_d;
      slot_q       <= slot_d;
      inst_valid_q <= inst_valid_d;
      inv_q        <= inv_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [XLEN-1:0] perf_redirects_q;
  logic [XLEN-1:0] perf_stalls_q;

  // Redirect and decode-backpressure event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_redirects_q <= '0;
      perf_stalls_q    <= '0;
    end else begin
      if (redir_c) begin
        perf_redirects_q <= perf_redirects_q + XLEN'(1);
      end
      if (inst_valid_q && !dec_ready) begin
        perf_stalls_q <= perf_stalls_q + XLEN'(1);
      end
    end
  end

  assign perf_redirects = perf_redirects_q;
  assign perf_stalls    = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a fixed-latency memory responder.
// Perf counter checks are compiled in when FETCH_CTRL_PERF_EN is defined.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid;
  logic [63:0] trap_addr;
  logic        mispred;
  logic [63:0] tp_addr;
  logic        fence_i;
  logic [63:0] fence_pc;
  logic        taken;
  logic [63:0] paddr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        icache_inv_req;
  logic        icache_inv_done;
  logic        inst_valid;
  logic        dec_ready;
  logic [31:0] inst;
  logic [63:0] inst_addr;
`ifdef FETCH_CTRL_PERF_EN
  logic [63:0] perf_redirects;
  logic [63:0] perf_stalls;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  int          rsp_lat = 1;
  int          rsp_cnt = -1;
  logic [63:0] rsp_addr = '0;
  logic        xfer;
  logic [63:0] xaddr;
  logic [63:0] req_log[$];
  logic [63:0] inst_log[$];

  fetch_ctrl #(.RESET_VEC(64'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .trap_valid      (trap_valid),
    .trap_addr       (trap_addr),
    .mispred         (mispred),
    .tp_addr         (tp_addr),
    .fence_i         (fence_i),
    .fence_pc        (fence_pc),
    .taken           (taken),
    .paddr           (paddr),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .icache_inv_req  (icache_inv_req),
    .icache_inv_done (icache_inv_done),
`ifdef FETCH_CTRL_PERF_EN
    .perf_redirects  (perf_redirects),
    .perf_stalls     (perf_stalls),
`endif
    .inst_valid      (inst_valid),
    .dec_ready       (dec_ready),
    .inst            (inst),
    .inst_addr       (inst_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [63:0] a);
    return 32'h1300_0000 ^ a[31:0];
  endfunction

  // One clock: responder drive, sample, edge, bookkeeping; returns at negedge.
  task automatic cyc();
    imem_rsp_valid = (rsp_cnt == 0);
    imem_rsp_data  = (rsp_cnt == 0) ? mk(rsp_addr) : 32'h0;
    #1;
    xfer  = imem_req_valid && imem_req_ready;
    xaddr = imem_req_addr;
    if (inst_valid && dec_ready) inst_log.push_back(inst_addr);
    @(posedge clk);
    if (rsp_cnt >= 0) rsp_cnt--;
    if (xfer) begin
      req_log.push_back(xaddr);
      rsp_cnt  = rsp_lat;
      rsp_addr = xaddr;
    end
    #1;
    imem_rsp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_reqs(input int n, output bit ok);
    int target;
    target = req_log.size() + n;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (req_log.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_inst(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc();
    cyc();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 64'h0) begin n_fail++; $display("FAIL rst_req_addr got %h want 0", imem_req_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid got %b want 0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %h want 0", inst); end
    n_cmp++; if (inst_addr !== 64'h0) begin n_fail++; $display("FAIL rst_inst_addr got %h want 0", inst_addr); end
    n_cmp++; if (icache_inv_req !== 1'b0) begin n_fail++; $display("FAIL rst_inv_req got %b want 0", icache_inv_req); end
    rst = 1'b1;
  endtask

  task automatic test_seq();
    bit ok;
    run_reqs(3, ok);
    n_cmp++; if (!ok || req_log.size() != 3) begin n_fail++; $display("FAIL seq_count got %0d want 3", req_log.size()); end
    n_cmp++; if (req_log[0] !== 64'h0) begin n_fail++; $display("FAIL seq_req0 got %h want 0", req_log[0]); end
    n_cmp++; if (req_log[1] !== 64'h4) begin n_fail++; $display("FAIL seq_req1 got %h want 4", req_log[1]); end
    n_cmp++; if (req_log[2] !== 64'h8) begin n_fail++; $display("FAIL seq_req2 got %h want 8", req_log[2]); end
    n_cmp++; if (inst_log.size() != 2 || inst_log[0] !== 64'h0 || inst_log[1] !== 64'h4) begin
      n_fail++; $display("FAIL seq_decode got n=%0d first=%h want n=2 0,4", inst_log.size(), inst_log[0]);
    end
  endtask

  task automatic test_mispred();
    bit ok;
    mispred = 1'b1; tp_addr = 64'h1000;
    cyc();
    mispred = 1'b0;
    n_cmp++; if (imem_req_addr !== 64'h1000) begin n_fail++; $display("FAIL mp_pc got %h want 1000", imem_req_addr); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mp_wait got %b want 0", imem_req_valid); end
    cyc();
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mp_drop got %b want 0", inst_valid); end
    run_reqs(1, ok);
    n_cmp++; if (!ok || req_log[req_log.size()-1] !== 64'h1000) begin n_fail++; $display("FAIL mp_req got %h want 1000", req_log[req_log.size()-1]); end
    wait_inst(ok);
    n_cmp++; if (!ok || inst_addr !== 64'h1000 || inst !== 32'h1300_1000) begin
      n_fail++; $display("FAIL mp_inst got %h/%h want 1000/13001000", inst_addr, inst);
    end
    cyc();
    n_cmp++; if (inst_log[inst_log.size()-2] !== 64'h4) begin n_fail++; $display("FAIL mp_killed got %h want 4", inst_log[inst_log.size()-2]); end
  endtask

  task automatic test_trap_prio();
    bit ok;
    trap_valid = 1'b1; trap_addr = 64'h200;
    mispred = 1'b1; tp_addr = 64'h300;
    cyc();
    trap_valid = 1'b0; mispred = 1'b0;
    n_cmp++; if (imem_req_addr !== 64'h200) begin n_fail++; $display("FAIL prio_pc got %h want 200", imem_req_addr); end
    run_reqs(1, ok);
    n_cmp++; if (!ok || req_log[req_log.size()-1] !== 64'h200) begin n_fail++; $display("FAIL prio_req got %h want 200", req_log[req_log.size()-1]); end
  endtask

  task automatic test_fence();
    bit ok;
    run_reqs(1, ok);
    fence_i = 1'b1; fence_pc = 64'h40;
    cyc();
    fence_i = 1'b0;
    n_cmp++; if (icache_inv_req !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL fence_drain got inv=%b req=%b want 0/0", icache_inv_req, imem_req_valid);
    end
    cyc();
    n_cmp++; if (icache_inv_req !== 1'b1) begin n_fail++; $display("FAIL fence_flush got %b want 1", icache_inv_req); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (icache_inv_req !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL fence_hold got inv=%b req=%b iv=%b want 1/0/0", icache_inv_req, imem_req_valid, inst_valid);
      end
    end
    icache_inv_done = 1'b1;
    cyc();
    icache_inv_done = 1'b0;
    n_cmp++; if (icache_inv_req !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h44) begin
      n_fail++; $display("FAIL fence_resume got inv=%b req=%b addr=%h want 0/1/44", icache_inv_req, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_fence_redirect();
    bit ok;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    fence_i = 1'b1; fence_pc = 64'h80;
    cyc();
    fence_i = 1'b0;
    n_cmp++; if (icache_inv_req !== 1'b1) begin n_fail++; $display("FAIL fr_flush got %b want 1", icache_inv_req); end
    mispred = 1'b1; tp_addr = 64'h500;
    cyc();
    mispred = 1'b0;
    n_cmp++; if (icache_inv_req !== 1'b1) begin n_fail++; $display("FAIL fr_stay got %b want 1", icache_inv_req); end
    icache_inv_done = 1'b1;
    cyc();
    icache_inv_done = 1'b0;
    imem_req_ready = 1'b1;
    run_reqs(1, ok);
    n_cmp++; if (!ok || req_log[req_log.size()-1] !== 64'h500) begin n_fail++; $display("FAIL fr_req got %h want 500", req_log[req_log.size()-1]); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] held;
    wait_inst(ok);
    n_cmp++; if (!ok || inst_addr !== 64'h500) begin n_fail++; $display("FAIL stall_inst got %h want 500", inst_addr); end
    held = 32'h1300_0500;
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (inst_valid !== 1'b1 || inst !== held || inst_addr !== 64'h500 || imem_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold got iv=%b inst=%h req=%b want 1/%h/0", inst_valid, inst, imem_req_valid, held);
      end
      cyc();
    end
`ifdef FETCH_CTRL_PERF_EN
    n_cmp++; if (perf_stalls !== 64'd5) begin n_fail++; $display("FAIL perf_stalls got %0d want 5", perf_stalls); end
    n_cmp++; if (perf_redirects !== 64'd3) begin n_fail++; $display("FAIL perf_redirects got %0d want 3", perf_redirects); end
`endif
    dec_ready = 1'b1;
  endtask

  task automatic test_wrap();
    bit ok;
    trap_valid = 1'b1; trap_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc();
    trap_valid = 1'b0;
    run_reqs(2, ok);
    n_cmp++; if (!ok || req_log[req_log.size()-2] !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_top got %h want fffffffffffffffc", req_log[req_log.size()-2]); end
    n_cmp++; if (req_log[req_log.size()-1] !== 64'h0) begin n_fail++; $display("FAIL wrap_zero got %h want 0", req_log[req_log.size()-1]); end
  endtask

  task automatic test_taken();
    bit ok;
    trap_valid = 1'b1; trap_addr = 64'h100;
    cyc();
    trap_valid = 1'b0;
    taken = 1'b1; paddr = 64'h800;
    run_reqs(1, ok);
    taken = 1'b0;
    n_cmp++; if (!ok || req_log[req_log.size()-1] !== 64'h100) begin n_fail++; $display("FAIL taken_src got %h want 100", req_log[req_log.size()-1]); end
    run_reqs(1, ok);
    n_cmp++; if (!ok || req_log[req_log.size()-1] !== 64'h800) begin n_fail++; $display("FAIL taken_tgt got %h want 800", req_log[req_log.size()-1]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    rsp_lat = 3;
    run_reqs(1, ok);
    rst = 1'b0; imem_req_ready = 1'b0;
    cyc();
    rst = 1'b1;
    n_cmp++; if (imem_req_addr !== 64'h0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_state got addr=%h iv=%b want 0/0", imem_req_addr, inst_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (inst_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_drop got %b want 0", seen); end
  endtask

  initial begin
    rst = 1'b0; trap_valid = 1'b0; trap_addr = '0; mispred = 1'b0; tp_addr = '0;
    fence_i = 1'b0; fence_pc = '0; taken = 1'b0; paddr = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    icache_inv_done = 1'b0; dec_ready = 1'b1;
    test_reset();
    test_seq();
    test_mispred();
    test_trap_prio();
    test_fence();
    test_fence_redirect();
    test_stall();
    test_wrap();
    test_taken();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
